// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: holds one instruction between EX and WB, waits for the
// in-order data-SRAM response of loads/stores, extracts sub-word load data,
// buffers the response while WB stalls and discards responses owed to
// instructions killed by a flush.
module mem_stage_hs #(
    parameter  int XLEN            = 32,
    parameter  int PC_W            = 32,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int ES2MS_W         = 11 + XLEN + PC_W,
    localparam int MS2WS_W         = 6 + XLEN + PC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    output logic               ms_allowin,
    input  logic               es2ms_valid,
    input  logic [ES2MS_W-1:0] es2ms_bus,
    output logic               ms2ws_valid,
    input  logic               ws_allowin,
    output logic [MS2WS_W-1:0] ms2ws_bus,
    output logic [6+XLEN-1:0]  ms_rf_zip,
    output logic               ms_ld_pending,
    input  logic               data_sram_data_ok,
    input  logic [XLEN-1:0]    data_sram_rdata
);

    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    // Fields of the instruction offered by EX
    logic            w_in_req;
    logic            w_in_res;
    logic            w_in_sgn;
    logic [1:0]      w_in_size;
    logic            w_in_we;
    logic [4:0]      w_in_waddr;
    logic [XLEN-1:0] w_in_alu;
    logic [PC_W-1:0] w_in_pc;

    assign {w_in_req, w_in_res, w_in_sgn, w_in_size, w_in_we,
            w_in_waddr, w_in_alu, w_in_pc} = es2ms_bus;

    // Stage state
    logic             r_valid;
    logic             r_req_issued;
    logic             r_res_from_mem;
    logic             r_ld_signed;
    logic [1:0]       r_ld_size;
    logic             r_rf_we;
    logic [4:0]       r_rf_waddr;
    logic [XLEN-1:0]  r_alu_result;
    logic [PC_W-1:0]  r_pc;
    logic             r_buf_valid;
    logic [XLEN-1:0]  r_buf_data;
    logic [CNT_W-1:0] r_drop_cnt;

    logic            w_own_ok;
    logic            w_ready_go;
    logic            w_accept;
    logic            w_leave;
    logic            w_capture;
    logic            w_drop_inc;
    logic            w_drop_dec;
    logic [XLEN-1:0] w_mem_data;
    logic [XLEN-1:0] w_rf_wdata;

    // Shift the addressed bytes down, keep 8/16/32/64 bits and fill the rest
    // with zeros or the sign bit. A doubleword on a 32-bit core reads as zero.
    function automatic logic [XLEN-1:0] f_load_extract(
        input logic [XLEN-1:0]  data,
        input logic [OFF_W-1:0] off,
        input logic [1:0]       size,
        input logic             sgn
    );
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] res;
        logic            fill;
        int              nbits;
        shifted = data >> {off, 3'b000};
        nbits   = 8 << size;
        res     = '0;
        case (size)
            2'd0:    fill = sgn & shifted[7];
            2'd1:    fill = sgn & shifted[15];
            2'd2:    fill = sgn & shifted[31];
            default: fill = sgn & shifted[XLEN-1];
        endcase
        if (nbits <= XLEN) begin
            for (int i = 0; i < XLEN; i++) begin
                res[i] = (i < nbits) ? shifted[i] : fill;
            end
        end
        return res;
    endfunction

    // Count of responses still owed to killed instructions; holds at the cap.
    function automatic logic [CNT_W-1:0] f_drop_next(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec) begin
            nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end else if (dec && !inc) begin
            nxt = cnt - 1'b1;
        end
        return nxt;
    endfunction

    // A response belongs to this entry only once every dropped one has drained
    assign w_own_ok   = data_sram_data_ok & (r_drop_cnt == '0);
    assign w_ready_go = ~r_req_issued | w_own_ok | r_buf_valid;
    assign ms_allowin = ~r_valid | (w_ready_go & ws_allowin);
    assign w_accept   = ms_allowin & ~flush & es2ms_valid;
    assign w_leave    = r_valid & w_ready_go & ws_allowin;
    assign w_capture  = w_own_ok & r_valid & r_req_issued & ~r_buf_valid & ~ws_allowin;
    assign w_drop_inc = flush & r_valid & r_req_issued & ~r_buf_valid & ~w_own_ok;
    assign w_drop_dec = data_sram_data_ok & (r_drop_cnt != '0);

    assign w_mem_data    = r_buf_valid ? r_buf_data : data_sram_rdata;
    assign w_rf_wdata    = r_res_from_mem
                         ? f_load_extract(w_mem_data, r_alu_result[OFF_W-1:0], r_ld_size, r_ld_signed)
                         : r_alu_result;
    assign ms2ws_valid   = r_valid & w_ready_go & ~flush;
    assign ms_ld_pending = r_valid & r_res_from_mem & ~w_ready_go;
    assign ms2ws_bus     = {r_rf_we, r_rf_waddr, w_rf_wdata, r_pc};
    assign ms_rf_zip     = {r_rf_we & r_valid, r_rf_waddr, w_rf_wdata};

    // Occupancy: flush empties the slot, otherwise refill whenever it can accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_valid <= es2ms_valid;
        end
    end

    // Instruction fields are captured only with a real accepted instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_issued   <= 1'b0;
            r_res_from_mem <= 1'b0;
            r_ld_signed    <= 1'b0;
            r_ld_size      <= 2'd0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= 5'd0;
            r_alu_result   <= '0;
            r_pc           <= '0;
        end else if (w_accept) begin
            r_req_issued   <= w_in_req;
            r_res_from_mem <= w_in_res;
            r_ld_signed    <= w_in_sgn;
            r_ld_size      <= w_in_size;
            r_rf_we        <= w_in_we;
            r_rf_waddr     <= w_in_waddr;
            r_alu_result   <= w_in_alu;
            r_pc           <= w_in_pc;
        end
    end

    // Hold the response while WB stalls; released when the entry leaves or dies
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
        end else if (flush || w_leave) begin
            r_buf_valid <= 1'b0;
        end else if (w_capture) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= data_sram_rdata;
        end
    end

    // Track responses still owed to instructions killed while waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= f_drop_next(r_drop_cnt, w_drop_inc, w_drop_dec);
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: a 32-bit instance exercised with directed and random
// traffic against a transaction-level model (one-slot stage plus an in-order
// memory response queue tagged live/dead), and a 64-bit instance for load
// extraction with immediate responses.
module tb_mem_stage_hs;

    localparam int W32_IN  = 11 + 32 + 32;
    localparam int W32_OUT = 6 + 32 + 32;
    localparam int W64_IN  = 11 + 64 + 32;
    localparam int W64_OUT = 6 + 64 + 32;

    logic clk;
    logic reset;

    logic               flush;
    logic               ms_allowin;
    logic               es2ms_valid;
    logic [W32_IN-1:0]  es2ms_bus;
    logic               ms2ws_valid;
    logic               ws_allowin;
    logic [W32_OUT-1:0] ms2ws_bus;
    logic [37:0]        ms_rf_zip;
    logic               ms_ld_pending;
    logic               data_ok;
    logic [31:0]        rdata;

    logic               flush_64;
    logic               allowin_64;
    logic               es_valid_64;
    logic [W64_IN-1:0]  es_bus_64;
    logic               ws_valid_64;
    logic               ws_allowin_64;
    logic [W64_OUT-1:0] ws_bus_64;
    logic [69:0]        zip_64;
    logic               pend_64;
    logic               data_ok_64;
    logic [63:0]        rdata_64;

    mem_stage_hs #(.XLEN(32), .PC_W(32), .MAX_OUTSTANDING(2)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .ms_allowin(ms_allowin),
        .es2ms_valid(es2ms_valid), .es2ms_bus(es2ms_bus), .ms2ws_valid(ms2ws_valid),
        .ws_allowin(ws_allowin), .ms2ws_bus(ms2ws_bus), .ms_rf_zip(ms_rf_zip),
        .ms_ld_pending(ms_ld_pending), .data_sram_data_ok(data_ok), .data_sram_rdata(rdata)
    );

    mem_stage_hs #(.XLEN(64), .PC_W(32), .MAX_OUTSTANDING(2)) u_dut64 (
        .clk(clk), .reset(reset), .flush(flush_64), .ms_allowin(allowin_64),
        .es2ms_valid(es_valid_64), .es2ms_bus(es_bus_64), .ms2ws_valid(ws_valid_64),
        .ws_allowin(ws_allowin_64), .ms2ws_bus(ws_bus_64), .ms_rf_zip(zip_64),
        .ms_ld_pending(pend_64), .data_sram_data_ok(data_ok_64), .data_sram_rdata(rdata_64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference load semantics: take 1/2/4/8 bytes at the byte offset,
    // zero- or sign-extend to xlen; wider than xlen reads as zero.
    function automatic logic [63:0] ref_load(input logic [63:0] data, input int xlen,
                                             input int off, input int size, input bit sgn);
        int          nbits;
        logic [63:0] v;
        logic [63:0] mask;
        nbits = 8 * (1 << size);
        if (nbits > xlen) return 64'd0;
        v    = data >> (off * 8);
        mask = (nbits == 64) ? ~64'd0 : ((64'd1 << nbits) - 64'd1);
        v    = v & mask;
        if (sgn && (((v >> (nbits - 1)) & 64'd1) != 64'd0) && nbits < xlen) v = v | ~mask;
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic [W32_IN-1:0] mk32(input bit req, input bit res, input bit sgn,
                                               input bit [1:0] size, input bit we,
                                               input bit [4:0] waddr, input bit [31:0] alu,
                                               input bit [31:0] pc);
        return {req, res, sgn, size, we, waddr, alu, pc};
    endfunction

    // Model: the instruction held in MEM and the queue of outstanding
    // memory requests in issue order (1 = its owner is alive, 0 = killed).
    typedef struct {
        bit        req;
        bit        res;
        bit        sgn;
        bit [1:0]  size;
        bit        we;
        bit [4:0]  waddr;
        bit [31:0] alu;
        bit [31:0] pc;
        bit        got;
        bit [31:0] data;
    } ins_t;

    ins_t cur;
    bit   cur_valid;
    bit   pend[$];

    bit          obs_v;
    bit          obs_pend;
    bit          obs_aw;
    logic [31:0] obs_wd;
    logic [63:0] obs_wd64;

    // One clock of the 32-bit instance: drive, compare against the model, advance.
    task automatic step(input bit ev, input logic [W32_IN-1:0] bus, input bit wa,
                        input bit fl, input bit dok, input logic [31:0] rd);
        bit          head_live;
        bit          ready;
        bit          exp_v;
        bit          exp_aw;
        bit          exp_pend;
        logic [31:0] src;
        logic [31:0] exp_wd;
        ins_t        nin;
        es2ms_valid = ev;
        es2ms_bus   = bus;
        ws_allowin  = wa;
        flush       = fl;
        data_ok     = dok;
        rdata       = rd;
        #1;
        head_live = dok && (pend.size() > 0) && pend[0];
        ready     = cur_valid && (!cur.req || cur.got || head_live);
        exp_v     = ready && !fl;
        exp_aw    = !cur_valid || (ready && wa);
        exp_pend  = cur_valid && cur.res && !ready;
        src       = cur.got ? cur.data : rd;
        exp_wd    = cur.res ? ref_load({32'd0, src}, 32, int'(cur.alu[1:0]), int'(cur.size), cur.sgn) : cur.alu;
        check("ms_allowin", ms_allowin, exp_aw);
        check("ms2ws_valid", ms2ws_valid, exp_v);
        check("ms_ld_pending", ms_ld_pending, exp_pend);
        if (exp_v) begin
            check("ms2ws_bus", ms2ws_bus, {cur.we, cur.waddr, exp_wd, cur.pc});
            check("ms_rf_zip", ms_rf_zip, {cur.we, cur.waddr, exp_wd});
        end else if (!cur_valid) begin
            check("rf_zip_we", ms_rf_zip[37], 1'b0);
        end
        obs_v    = ms2ws_valid;
        obs_pend = ms_ld_pending;
        obs_aw   = ms_allowin;
        obs_wd   = ms2ws_bus[63:32];
        if (dok && pend.size() > 0) begin
            if (pend[0]) begin
                cur.got  = 1'b1;
                cur.data = rd;
            end
            void'(pend.pop_front());
        end
        if (fl) begin
            if (cur_valid && cur.req && !cur.got) pend[pend.size() - 1] = 1'b0;
            cur_valid = 1'b0;
        end else if (exp_aw) begin
            if (ev) begin
                {nin.req, nin.res, nin.sgn, nin.size, nin.we, nin.waddr, nin.alu, nin.pc} = bus;
                nin.got   = 1'b0;
                nin.data  = 32'd0;
                cur       = nin;
                cur_valid = 1'b1;
                if (nin.req) pend.push_back(1'b1);
            end else begin
                cur_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // One instruction through the 64-bit instance, response in its first MEM cycle.
    task automatic run64(input bit req, input bit res, input bit sgn, input bit [1:0] size,
                         input logic [63:0] alu, input logic [63:0] rd, input string tag);
        logic [63:0] exp_wd;
        es_valid_64   = 1'b1;
        es_bus_64     = {req, res, sgn, size, 1'b1, 5'd7, alu, 32'h0000_0064};
        ws_allowin_64 = 1'b1;
        data_ok_64    = 1'b0;
        rdata_64      = 64'd0;
        @(negedge clk);
        es_valid_64 = 1'b0;
        es_bus_64   = '0;
        data_ok_64  = req;
        rdata_64    = rd;
        #1;
        exp_wd = res ? ref_load(rd, 64, int'(alu[2:0]), int'(size), sgn) : alu;
        check({tag, "_valid"}, ws_valid_64, 1'b1);
        check({tag, "_wdata"}, ws_bus_64[95:32], exp_wd);
        obs_wd64 = ws_bus_64[95:32];
        @(negedge clk);
        data_ok_64 = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        flush         = 1'b0;
        es2ms_valid   = 1'b0;
        es2ms_bus     = '0;
        ws_allowin    = 1'b0;
        data_ok       = 1'b0;
        rdata         = 32'd0;
        flush_64      = 1'b0;
        es_valid_64   = 1'b0;
        es_bus_64     = '0;
        ws_allowin_64 = 1'b0;
        data_ok_64    = 1'b0;
        rdata_64      = 64'd0;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        cur_valid = 1'b0;
        pend.delete();
    endtask

    bit          s_ev;
    bit          s_wa;
    bit          s_fl;
    bit          s_dok;
    int          s_op;
    int          s_dead;
    logic [31:0] s_rd;
    logic [W32_IN-1:0] s_bus;

    initial begin
        do_reset();
        #1;
        check("rst_allowin", ms_allowin, 1'b1);
        check("rst_valid", ms2ws_valid, 1'b0);
        check("rst_pending", ms_ld_pending, 1'b0);
        check("rst_zip", ms_rf_zip, 38'd0);
        check("rst_zip64", zip_64, 70'd0);
        @(negedge clk);

        // 64-bit extraction
        run64(1'b1, 1'b1, 1'b1, 2'd2, 64'h0000_0000_0000_1004, 64'h8000_0001_0000_0000, "ldw64");
        check("ldw64_const", obs_wd64, 64'hFFFF_FFFF_8000_0001);
        run64(1'b0, 1'b0, 1'b0, 2'd0, 64'h1234_5678_9ABC_DEF0, 64'd0, "alu64");
        check("alu64_const", obs_wd64, 64'h1234_5678_9ABC_DEF0);
        for (int k = 0; k < 16; k++) begin
            run64(1'b1, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  {$urandom, $urandom}, {$urandom, $urandom}, "ld64_rand");
        end

        // ld.b signed, zero-latency response
        step(1'b1, mk32(1, 1, 1, 2'd0, 1, 5'd3, 32'h1003, 32'h100), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h8011_2233);
        check("ldb_valid", obs_v, 1'b1);
        check("ldb_wdata", obs_wd, 32'hFFFF_FF80);

        // ld.hu, response after three waiting cycles
        step(1'b1, mk32(1, 1, 0, 2'd1, 1, 5'd4, 32'h2002, 32'h104), 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, 32'h0);
            check("ldhu_pending", obs_pend, 1'b1);
            check("ldhu_allowin", obs_aw, 1'b0);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'hBEEF_0000);
        check("ldhu_wdata", obs_wd, 32'h0000_BEEF);

        // ld.w response while WB stalls, then bus changes
        step(1'b1, mk32(1, 1, 1, 2'd2, 1, 5'd5, 32'h3000, 32'h108), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 32'hFFFF_0000);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5);
        check("buf_valid", obs_v, 1'b1);
        check("buf_wdata", obs_wd, 32'h1234_5678);

        // flush in WAIT: the late response is dropped, the next load gets its own
        step(1'b1, mk32(1, 1, 0, 2'd2, 1, 5'd6, 32'h4000, 32'h10C), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, mk32(0, 0, 0, 2'd0, 1, 5'd1, 32'hFFFF, 32'h0), 1'b1, 1'b1, 1'b0, 32'h0);
        check("flush_valid", obs_v, 1'b0);
        step(1'b1, mk32(1, 1, 0, 2'd2, 1, 5'd7, 32'h5000, 32'h110), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0000_DEAD);
        check("drop_valid", obs_v, 1'b0);
        check("drop_pending", obs_pend, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0000_CAFE);
        check("own_valid", obs_v, 1'b1);
        check("own_wdata", obs_wd, 32'h0000_CAFE);

        // flush together with the response: consumed, nothing owed afterwards
        step(1'b1, mk32(1, 1, 0, 2'd2, 1, 5'd8, 32'h6000, 32'h114), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h1111_1111);
        check("flushok_valid", obs_v, 1'b0);
        step(1'b1, mk32(0, 0, 0, 2'd0, 1, 5'd9, 32'h55, 32'h118), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("alu_wdata", obs_wd, 32'h0000_0055);
        step(1'b1, mk32(1, 1, 0, 2'd0, 1, 5'd10, 32'h7001, 32'h11C), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0000_AB00);
        check("after_flushok_wdata", obs_wd, 32'h0000_00AB);

        // reset with a response owed clears the drop count
        step(1'b1, mk32(1, 1, 0, 2'd2, 1, 5'd11, 32'h8000, 32'h120), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, mk32(1, 1, 0, 2'd2, 1, 5'd12, 32'h9000, 32'h124), 1'b1, 1'b0, 1'b0, 32'h0);
        do_reset();
        step(1'b1, mk32(1, 1, 1, 2'd1, 1, 5'd13, 32'hA002, 32'h128), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'hF00F_0000);
        check("rst_wait_valid", obs_v, 1'b1);
        check("rst_wait_wdata", obs_wd, 32'hFFFF_F00F);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            s_dead = 0;
            foreach (pend[i]) if (!pend[i]) s_dead++;
            s_ev  = ($urandom_range(0, 9) < 7);
            s_op  = $urandom_range(0, 2);
            s_bus = mk32(s_op != 0, s_op == 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom);
            s_wa  = ($urandom_range(0, 9) < 7);
            s_fl  = (s_dead < 2) && ($urandom_range(0, 19) == 0);
            s_dok = (pend.size() > 0) && ($urandom_range(0, 9) < 4);
            s_rd  = $urandom;
            step(s_ev, s_bus, s_wa, s_fl, s_dok, s_rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Parametrised MEM pipeline stage for the in-order core. It accepts the EX→MEM bus and waits for the data-SRAM response when a load or store request was issued in EX, tolerating multi-cycle memory latency. It extracts and sign/zero-extends sub-word load data for XLEN 32 or 64, buffers the response when WB stalls, and cancels in-flight work on pipeline flush. It sits between the EX stage and the WB stage and drives the MEM forwarding/blocking bus to ID.

Parameters:
XLEN, 32, data/register width; 32 or 64
PC_W, 32, PC width
MAX_OUTSTANDING, 2, maximum number of cancelled SRAM responses the stage can still owe; sizes drop_cnt
localparam ES2MS_W = 11+XLEN+PC_W; MS2WS_W = 6+XLEN+PC_W; OFF_W = log2(XLEN/8)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  exception/ertn flush; kills the MEM instruction
ms_allowin  out  1  MEM can accept from EX
es2ms_valid  in  1  EX presents an instruction
es2ms_bus  in  ES2MS_W  {req_issued, res_from_mem, ld_signed, ld_size[1:0], rf_we, rf_waddr[4:0], alu_result[XLEN-1:0], pc[PC_W-1:0]}
ms2ws_valid  out  1  MEM presents an instruction to WB
ws_allowin  in  1  WB can accept
ms2ws_bus  out  MS2WS_W  {rf_we, rf_waddr, rf_wdata, pc}
ms_rf_zip  out  6+XLEN  {rf_we&ms_valid, rf_waddr, rf_wdata}, forwarding to ID
ms_ld_pending  out  1  ms_valid & res_from_mem & ~ready_go; ID must stall on a hazard
data_sram_data_ok  in  1  response strobe, in request order
data_sram_rdata  in  XLEN  response data

Behaviour:
- Reset: ms_valid=0, all bus registers 0, buf_valid=0, drop_cnt=0. Consequently ms2ws_valid=0, ms_ld_pending=0, ms_rf_zip=0, ms_allowin=1.
- own_ok = data_sram_data_ok & (drop_cnt==0).
- ready_go = ~req_issued | own_ok | buf_valid.
- ms_allowin = ~ms_valid | (ready_go & ws_allowin).
- ms2ws_valid = ms_valid & ready_go & ~flush.
- Load on ms_allowin & ~flush: ms_valid<=es2ms_valid. Bus registers load only when es2ms_valid is also high.
- In a flush cycle: ms_valid<=0 and es2ms_valid is ignored.
- Effective state per entry: EMPTY (~ms_valid); WAIT (ms_valid & req_issued & ~buf_valid); READY (otherwise).
  - WAIT→READY on own_ok.
  - READY→EMPTY/next when WB accepts.
- Response buffer: if own_ok & ms_valid & ~ws_allowin, capture rdata and set buf_valid=1. buf_valid clears when the entry leaves MEM or on flush.
- Result data source: buf_valid ? buffered data : data_sram_rdata. A zero-latency response (data_ok in the first MEM cycle) is legal.
- Load extraction:
  - shifted = data >> (alu_result[OFF_W-1:0]*8).
  - ld_size 0=B, 1=H, 2=W, 3=D. Extension uses ld_signed.
  - W with XLEN=32 passes through unchanged.
  - D with XLEN=32 yields 0.
- rf_wdata = res_from_mem ? load_result : alu_result.
- Stores: req_issued=1, res_from_mem=0. MEM still waits for data_ok, and rf_wdata comes from alu_result.
- Flush while in WAIT with no data_ok that cycle: drop_cnt++ so the late response is discarded.
- Flush in the same cycle as own_ok: the response is consumed and discarded; drop_cnt unchanged.
- data_ok with drop_cnt>0: drop_cnt--; the current entry is not affected.
- drop_cnt saturates at MAX_OUTSTANDING. Upstream guarantees no overflow.
- Reset mid-WAIT clears drop_cnt. Any stale response after reset is the memory interface's responsibility.

Test Plan:
- XLEN=32: ld.b signed at alu_result=0x1003, rdata=0x80_11_22_33, data_ok in cycle 0, ws_allowin=1 → ms2ws_valid same cycle, rf_wdata=0xFFFFFF80.
- ld.hu at 0x2002, data_ok after 3 cycles → ms_ld_pending=1 for 3 cycles, ms_allowin=0; then rdata=0xBEEF0000 gives rf_wdata=0x0000BEEF.
- ld.w: data_ok arrives while ws_allowin=0 for 2 cycles, rdata=0x12345678, and the bus changes afterwards → buffered value 0x12345678 is delivered when ws_allowin rises.
- Load in WAIT, flush asserted; next load enters; first data_ok (0xDEAD) dropped with drop_cnt 1→0, second data_ok (0x0000CAFE) written → rf_wdata=0x0000CAFE.
- Flush in the same cycle as data_ok → no ms2ws_valid, drop_cnt stays 0, next instruction flows normally.
- XLEN=64: ld.w signed at offset 4, rdata=0x8000_0001_0000_0000 → rf_wdata=0xFFFFFFFF80000001. ALU op with req_issued=0 → passes alu_result in 1 cycle.
